// File: rtl/regression_run_sequencer_if.sv
// Host/core-facing signal bundle of the regression run sequencer.
// The sequencer connects through the slave modport; the environment drives through master.
interface regression_run_sequencer_if #(
   parameter int W  = 20,
   parameter int AW = 8,
   parameter int CW = 16
);
   logic          go;
   logic          busy;
   logic          done;
   logic          in_valid;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata_x;
   logic [W-1:0]  mem_wdata_y;
   logic          core_start;
   logic          core_ready;
   logic [W-1:0]  err_rd_data;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          out_ready;
   logic [CW-1:0] run_cycles;

   modport master (
      output go, in_valid, in_x, in_y, core_ready, err_rd_data, out_ready,
      input  busy, done, in_ready, mem_we, mem_addr, mem_wdata_x, mem_wdata_y,
             core_start, out_valid, out_data, out_last, run_cycles
   );

   modport slave (
      input  go, in_valid, in_x, in_y, core_ready, err_rd_data, out_ready,
      output busy, done, in_ready, mem_we, mem_addr, mem_wdata_x, mem_wdata_y,
             core_start, out_valid, out_data, out_last, run_cycles
   );
endinterface

// File: rtl/regression_run_sequencer.sv
// Run sequencer: loads N (x,y) samples, kicks the regression core, waits for it,
// then streams the N error values out. Outputs are combinational decodes of state/idx.
module regression_run_sequencer #(
   parameter int N  = 150,
   parameter int W  = 20,
   parameter int AW = 8,
   parameter int CW = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   regression_run_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      WAIT_BUSY,
      WAIT_DONE,
      DRAIN,
      DONE
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t        state, state_nx;
   logic [AW-1:0] idx, idx_nx;
   logic [CW-1:0] run_cycles_q, run_cycles_nx, run_cycles_inc;

   assign run_cycles_inc = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + CW'(1);
   assign bus.run_cycles = run_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         run_cycles_q <= '0;
      end else begin
         state        <= state_nx;
         idx          <= idx_nx;
         run_cycles_q <= run_cycles_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      idx_nx          = idx;
      run_cycles_nx   = run_cycles_q;
      bus.busy        = (state != IDLE);
      bus.done        = 1'b0;
      bus.in_ready    = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata_x = '0;
      bus.mem_wdata_y = '0;
      bus.core_start  = 1'b0;
      bus.out_valid   = 1'b0;
      bus.out_data    = '0;
      bus.out_last    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.go) begin
               state_nx = LOAD;
               idx_nx   = '0;
            end
         end
         LOAD: begin
            bus.in_ready    = 1'b1;
            bus.mem_we      = bus.in_valid;
            bus.mem_addr    = idx;
            bus.mem_wdata_x = W'(bus.in_x);
            bus.mem_wdata_y = W'(bus.in_y);
            if (bus.in_valid) begin
               if (idx == LAST) begin
                  state_nx = KICK;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + AW'(1);
               end
            end
         end
         KICK: begin
            // Start follows core_ready so the pulse is exactly one cycle wide.
            bus.core_start = bus.core_ready;
            if (bus.core_ready) begin
               state_nx      = WAIT_BUSY;
               run_cycles_nx = '0;
            end
         end
         WAIT_BUSY: begin
            run_cycles_nx = run_cycles_inc;
            if (!bus.core_ready) state_nx = WAIT_DONE;
         end
         WAIT_DONE: begin
            run_cycles_nx = run_cycles_inc;
            if (bus.core_ready) begin
               state_nx = DRAIN;
               idx_nx   = '0;
            end
         end
         DRAIN: begin
            bus.mem_addr  = idx;
            bus.out_valid = 1'b1;
            bus.out_data  = W'(bus.err_rd_data);
            bus.out_last  = (idx == LAST);
            if (bus.out_ready) begin
               if (idx == LAST) begin
                  state_nx = DONE;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + AW'(1);
               end
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_regression_run_sequencer.sv
// Scoreboard bench for regression_run_sequencer: stimulus queues expected writes and
// error-stream beats; a negedge monitor pops and compares them as the DUT presents them.
module tb_regression_run_sequencer;
   localparam int N        = 150;
   localparam int W        = 20;
   localparam int AW       = 8;
   localparam int CW       = 16;
   localparam int BUSY_CYC = 460;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regression_run_sequencer_if #(.W(W), .AW(AW), .CW(CW)) bus ();

   regression_run_sequencer #(.N(N), .W(W), .AW(AW), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [W-1:0]  x;
      logic [W-1:0]  y;
   } wr_t;

   typedef struct packed {
      logic         last;
      logic [W-1:0] data;
   } rd_t;

   wr_t wq[$];
   rd_t oq[$];

   int checks   = 0;
   int failures = 0;
   int starts   = 0;
   int dones    = 0;

   logic core_busy = 1'b0;
   logic core_hold = 1'b0;

   // Core model idles with ready high; error memory returns 1000 + address.
   assign bus.core_ready  = !core_busy && !core_hold;
   assign bus.err_rd_data = W'(1000) + W'(bus.mem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Core: one start pulse makes it busy (ready low) for BUSY_CYC cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.core_start === 1'b1) begin
            @(posedge clk);
            #1 core_busy = 1'b1;
            repeat (BUSY_CYC) @(posedge clk);
            #1 core_busy = 1'b0;
         end
      end
   end

   logic         prev_valid = 1'b0;
   logic         prev_stall = 1'b0;
   logic         prev_start = 1'b0;
   logic [W-1:0] prev_data  = '0;
   wr_t          wexp;
   rd_t          rexp;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_we === 1'b1) begin
            check("wr_expected", 32'(wq.size() != 0), 1);
            check("wr_ready", 32'(bus.in_ready), 1);
            if (wq.size() != 0) begin
               wexp = wq.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(wexp.addr));
               check("wr_x", 32'(bus.mem_wdata_x), 32'(wexp.x));
               check("wr_y", 32'(bus.mem_wdata_y), 32'(wexp.y));
            end
         end
         if (prev_stall) begin
            check("out_hold_valid", 32'(bus.out_valid), 1);
            check("out_hold_data", 32'(bus.out_data), 32'(prev_data));
         end
         if (bus.out_valid === 1'b1 && !prev_valid)
            check("run_cycles", 32'(bus.run_cycles), BUSY_CYC + 1);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check("out_expected", 32'(oq.size() != 0), 1);
            if (oq.size() != 0) begin
               rexp = oq.pop_front();
               check("out_data", 32'(bus.out_data), 32'(rexp.data));
               check("out_last", 32'(bus.out_last), 32'(rexp.last));
            end
         end
         if (bus.core_start === 1'b1) begin
            starts++;
            check("start_width", 32'(prev_start), 0);
         end
         if (bus.done === 1'b1) dones++;
         prev_valid = (bus.out_valid === 1'b1);
         prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
         prev_data  = bus.out_data;
         prev_start = (bus.core_start === 1'b1);
      end
   end

   task automatic load(input int count, input bit bubbles, input bit poke_go);
      int i   = 0;
      int cyc = 0;
      while (i < count) begin
         step();
         bus.go = poke_go && (cyc == 30);
         if (!bubbles || (cyc % 2 == 0)) begin
            bus.in_valid = 1'b1;
            bus.in_x     = W'(i);
            bus.in_y     = W'(2 * i + 3);
            wq.push_back('{addr: AW'(i), x: W'(i), y: W'(2 * i + 3)});
            i++;
         end else begin
            bus.in_valid = 1'b0;
         end
         cyc++;
      end
   endtask

   task automatic go_pulse();
      step();
      bus.go = 1'b1;
      @(negedge clk);
      check("go_lat_idle_ready", 32'(bus.in_ready), 0);
      check("go_lat_idle_busy", 32'(bus.busy), 0);
      step();
      bus.go = 1'b0;
      @(negedge clk);
      check("go_lat_load_ready", 32'(bus.in_ready), 1);
      check("go_lat_load_addr", 32'(bus.mem_addr), 0);
   endtask

   task automatic run_pass(input bit bubbles, input bit stall, input bit pokes);
      int cyc  = 0;
      bit seen = 1'b0;
      for (int i = 0; i < N; i++) oq.push_back('{last: (i == N - 1), data: W'(1000 + i)});
      go_pulse();
      core_hold = stall;
      load(N, bubbles, pokes);
      step();
      bus.in_valid = 1'b0;
      bus.go       = 1'b0;
      @(negedge clk);
      check("load_ready_drop", 32'(bus.in_ready), 0);
      check("load_all_written", 32'(wq.size()), 0);
      if (stall) begin
         for (int k = 0; k < 5; k++) begin
            check("kick_hold", 32'(bus.core_start), 0);
            step();
            if (k == 4) core_hold = 1'b0;
            @(negedge clk);
         end
      end
      check("kick_start", 32'(bus.core_start), 1);
      step();
      @(negedge clk);
      check("kick_pulse_end", 32'(bus.core_start), 0);
      while (!seen && cyc < 3000) begin
         step();
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.go        = pokes && (cyc == 100 || cyc == 520);
         @(negedge clk);
         if (pokes && cyc == 101) begin
            check("go_ignored_wait_ready", 32'(bus.in_ready), 0);
            check("go_ignored_wait_busy", 32'(bus.busy), 1);
         end
         if (pokes && cyc == 521) check("go_ignored_drain", 32'(bus.out_valid), 1);
         if (bus.done === 1'b1) seen = 1'b1;
         cyc++;
      end
      check("done_seen", 32'(seen), 1);
      check("done_busy", 32'(bus.busy), 1);
      check("drain_all_read", 32'(oq.size()), 0);
      oq.delete();
      step();
      bus.out_ready = 1'b0;
      bus.go        = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_done", 32'(bus.done), 0);
   endtask

   initial begin
      bus.go        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_run_cycles", 32'(bus.run_cycles), 0);

      // Abandon a run after 10 samples.
      go_pulse();
      load(10, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      step();
      step();
      rst          = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_in_ready", 32'(bus.in_ready), 0);
      check("abort_mem_we", 32'(bus.mem_we), 0);
      check("abort_writes", 32'(wq.size()), 0);
      step();
      bus.in_valid = 1'b0;

      run_pass(1'b1, 1'b1, 1'b1);
      run_pass(1'b0, 1'b0, 1'b0);

      repeat (3) step();
      check("total_starts", 32'(starts), 2);
      check("total_dones", 32'(dones), 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
